// File: rtl/idc_pkg.sv
// Shared definitions for the IDC ID-frame generator and checker.
package idc_pkg;

  localparam int ID_LEN_DEF = 10;

  typedef enum logic {
    COLLECT = 1'b0,
    CHECK   = 1'b1
  } idc_gen_state_e;

  // Returns {t[2:0], u[3:0]}: tens and ones digit of a 6-bit symbol.
  function automatic logic [6:0] digit_split(input logic [5:0] v);
    logic [2:0] t;
    logic [3:0] u;
    t = 3'(v / 6'd10);
    u = 4'(v % 6'd10);
    return {t, u};
  endfunction

  function automatic logic [5:0] check_digit(input logic [3:0] acc);
    return (acc == 4'd0) ? 6'd0 : (6'd10 - 6'(acc));
  endfunction

endpackage

// File: rtl/idc_weight_acc.sv
// One step of the IDC checksum: next = (acc + t + (u*w) % 10) % 10.
module idc_weight_acc
  import idc_pkg::*;
#(
  parameter int WW = 4
) (
  input  logic [5:0]    sym,
  input  logic [WW-1:0] weight,
  input  logic [3:0]    acc,
  output logic [3:0]    next_acc
);

  localparam int PW = WW + 4;

  logic [6:0]    tu;
  logic [2:0]    t;
  logic [3:0]    u;
  logic [PW-1:0] prod;
  logic [4:0]    sum;

  // Worst case sum is 9 + 6 + 9 = 24, so 5 bits hold it before the final mod.
  always_comb begin
    tu       = digit_split(sym);
    t        = tu[6:4];
    u        = tu[3:0];
    prod     = PW'(u) * PW'(weight);
    sum      = 5'(acc) + 5'(t) + 5'(prod % PW'(10));
    next_acc = 4'(sum % 5'd10);
  end

endmodule

// File: rtl/idc_gen.sv
// IDC check-symbol generator: forwards ID_LEN-1 payload symbols, then appends
// the check symbol with out_last, on valid/ready streams with back-pressure.
module idc_gen
  import idc_pkg::*;
#(
  parameter int ID_LEN = ID_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] in_id,
  output logic       in_ready,
  output logic       out_valid,
  output logic [5:0] out_id,
  output logic       out_last,
  input  logic       out_ready
);

  localparam int CW = $clog2(ID_LEN);
  localparam int WW = $clog2(ID_LEN + 1);

  localparam logic ST_COLLECT = COLLECT;
  localparam logic ST_CHECK   = CHECK;

  logic          state;
  logic [CW-1:0] cnt;
  logic [3:0]    acc;
  logic [3:0]    next_acc;
  logic [WW-1:0] weight;
  logic          slot_free;
  logic          in_xfer;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == ST_COLLECT) && slot_free;
  assign in_xfer   = in_valid && in_ready;
  assign weight    = WW'(ID_LEN) - WW'(cnt);

  idc_weight_acc #(
    .WW(WW)
  ) u_weight_acc (
    .sym      (in_id),
    .weight   (weight),
    .acc      (acc),
    .next_acc (next_acc)
  );

  // The check symbol is loaded as soon as the last payload leaves the output
  // register, so a stalled output simply holds everything in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_COLLECT;
      cnt       <= '0;
      acc       <= 4'd0;
      out_valid <= 1'b0;
      out_id    <= 6'd0;
      out_last  <= 1'b0;
    end else if (state == ST_COLLECT) begin
      if (in_xfer) begin
        out_id    <= in_id;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        acc       <= next_acc;
        cnt       <= cnt + 1'b1;
        if (cnt == CW'(ID_LEN - 2)) begin
          state <= ST_CHECK;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (slot_free) begin
      out_id    <= check_digit(acc);
      out_valid <= 1'b1;
      out_last  <= 1'b1;
      acc       <= 4'd0;
      cnt       <= '0;
      state     <= ST_COLLECT;
    end
  end

endmodule

// File: tb/tb_idc_gen.sv
// Self-checking bench for idc_gen: table of hand-computed frames plus
// latency, back-pressure, reset and back-to-back sequences.
module tb_idc_gen;

  typedef logic [8:0][5:0] frame_t;

  typedef struct packed {
    frame_t     p;
    logic [5:0] chk;
  } vec_t;

  typedef struct packed {
    logic [5:0] id;
    logic       last;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_id;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_id;
  logic       out_last;
  logic       out_ready;

  int   total;
  int   passed;
  int   stalls;
  obs_t obs_q[$];
  vec_t vecs[5];

  idc_gen #(
    .ID_LEN(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_id     (in_id),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change #1 after a rising edge, so the falling edge sees
  // exactly what the next rising edge will transfer.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0)
      obs_q.push_back('{id: out_id, last: out_last});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [5:0] ref_check(input frame_t p);
    int s;
    int v;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      v = int'(p[k]);
      s += v / 10 + ((v % 10) * (10 - k)) % 10;
    end
    s = s % 10;
    return (s == 0) ? 6'd0 : 6'(10 - s);
  endfunction

  task automatic push(input logic [5:0] v);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_id    = v;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      stalls++;
      budget++;
      @(negedge clk);
    end
    if (!in_ready) check_output("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input frame_t p);
    for (int k = 0; k < 9; k++) push(p[k]);
  endtask

  task automatic wait_obs(input int n);
    int budget;
    budget = 0;
    while (obs_q.size() < n && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    #1;
  endtask

  task automatic check_frame(input string tag, input frame_t p, input logic [5:0] chk);
    wait_obs(10);
    if (obs_q.size() < 10) begin
      check_output({tag, "_count"}, obs_q.size(), 10);
    end else begin
      for (int k = 0; k < 9; k++)
        check_output($sformatf("%s_echo%0d", tag, k),
                     int'({obs_q[k].id, obs_q[k].last}), int'({p[k], 1'b0}));
      check_output({tag, "_check"}, int'({obs_q[9].id, obs_q[9].last}), int'({chk, 1'b1}));
    end
    obs_q.delete();
  endtask

  initial begin
    frame_t p;
    logic [5:0] held;

    total     = 0;
    passed    = 0;
    stalls    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_id     = 6'd0;
    out_ready = 1'b1;

    vecs[0].p = '0; vecs[0].p[0] = 6'd12; vecs[0].chk = 6'd9;
    vecs[1].p = '0; for (int k = 0; k < 9; k++) vecs[1].p[k] = 6'(k + 1);
    vecs[1].chk = 6'd0;
    vecs[2].p = '0; vecs[2].p[8] = 6'd63; vecs[2].chk = 6'd8;
    vecs[3].p = '0; for (int k = 0; k < 9; k++) vecs[3].p[k] = 6'd63;
    vecs[3].chk = 6'd4;
    vecs[4].p = '0; vecs[4].p[0] = 6'd45; vecs[4].p[8] = 6'd7; vecs[4].chk = 6'd2;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_out_id", int'(out_id), 0);
    check_output("rst_out_last", int'(out_last), 0);
    check_output("rst_in_ready", int'(in_ready), 1);
    obs_q.delete();

    $display("[TB] frame 12,0..0 with latency checks");
    apply_stimulus(vecs[0].p);
    check_output("t1_in_ready_check", int'(in_ready), 0);
    check_output("t1_last_payload", int'({out_valid, out_id, out_last}), int'({1'b1, 6'd0, 1'b0}));
    @(posedge clk); #1;
    check_output("t1_check_sym", int'({out_valid, out_id, out_last}), int'({1'b1, 6'd9, 1'b1}));
    check_output("t1_in_ready_after", int'(in_ready), 1);
    @(posedge clk); #1;
    check_output("t1_drain", int'({out_valid, out_id, out_last}), int'({1'b0, 6'd9, 1'b0}));
    check_frame("t1", vecs[0].p, vecs[0].chk);

    $display("[TB] table-driven frames");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].p);
      check_frame($sformatf("vec%0d", i), vecs[i].p, vecs[i].chk);
    end

    $display("[TB] back-pressure mid-frame");
    fork
      apply_stimulus(vecs[3].p);
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_id;
        check_output("bp_valid0", int'(out_valid), 1);
        check_output("bp_in_ready0", int'(in_ready), 0);
        for (int c = 1; c < 3; c++) begin
          @(negedge clk);
          check_output($sformatf("bp_hold%0d", c), int'({out_valid, out_id}), int'({1'b1, held}));
          check_output($sformatf("bp_in_ready%0d", c), int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check_frame("bp", vecs[3].p, vecs[3].chk);

    $display("[TB] reset after 5 payload symbols");
    for (int k = 0; k < 5; k++) push(6'(k * 7 + 3));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("mid_rst_out_valid", int'({out_valid, out_last}), 0);
    check_output("mid_rst_out_id", int'(out_id), 0);
    check_output("mid_rst_in_ready", int'(in_ready), 1);
    obs_q.delete();
    for (int k = 0; k < 9; k++) p[k] = 6'($urandom_range(0, 63));
    apply_stimulus(p);
    check_frame("post_rst", p, ref_check(p));

    $display("[TB] back-to-back frames");
    repeat (2) @(posedge clk);
    #1;
    obs_q.delete();
    stalls = 0;
    begin
      frame_t fr[3];
      for (int f = 0; f < 3; f++) begin
        for (int k = 0; k < 9; k++) fr[f][k] = 6'($urandom_range(0, 63));
        apply_stimulus(fr[f]);
      end
      check_output("b2b_stalls", stalls, 2);
      wait_obs(30);
      check_output("b2b_count", obs_q.size(), 30);
      if (obs_q.size() >= 30) begin
        for (int f = 0; f < 3; f++) begin
          for (int k = 0; k < 9; k++)
            check_output($sformatf("b2b_f%0d_echo%0d", f, k),
                         int'({obs_q[f*10+k].id, obs_q[f*10+k].last}), int'({fr[f][k], 1'b0}));
          check_output($sformatf("b2b_f%0d_check", f),
                       int'({obs_q[f*10+9].id, obs_q[f*10+9].last}), int'({ref_check(fr[f]), 1'b1}));
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
